// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants and mul/div sequencer state encoding
package pipeline_pkg;

  localparam int REG_AW_DFLT    = 5;
  localparam int MD_LAT_MIN     = 2;
  localparam int MD_LAT_MAX     = 16;
  localparam int MD_CNT_W       = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_seq.sv
// rtl/md_seq.sv - RUN/MD_BUSY sequencer holding EX while a mul/div instruction completes
module md_seq
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic md_stall
);

  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 2);

  md_state_e            state, state_nxt;
  logic [MD_CNT_W-1:0]  md_cnt, md_cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    unique case (state)
      RUN: begin
        if (md_start) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        // counter reaching zero marks the release cycle; a new start is ignored here
        if (md_cnt != '0) md_cnt_nxt = md_cnt - 1'b1;
        else              state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    md_stall = 1'b0;
    if (reset) begin
      unique case (state)
        RUN:     md_stall = md_start;
        MD_BUSY: md_stall = (md_cnt != '0);
        default: md_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencing for the 5-stage core
// Optional HAZARD_PERF_CNT_EN adds stall-cycle and flush counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int REG_AW     = REG_AW_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_branch,
  input  logic              id_redirect,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              ex_md_start,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              stall_id_ex,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              md_busy
);

  logic md_stall;
  logic ex_match, mem_match;
  logic load_use, branch_hz, hz_stall;

  md_seq #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_seq (
    .clk      (clk),
    .reset    (reset),
    .md_start (ex_md_start),
    .md_stall (md_stall)
  );

  // r0 is hardwired zero, so it never creates a dependency
  always_comb begin
    ex_match  = (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    mem_match = (mem_rd != '0) &&
                ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));
  end

  always_comb begin
    load_use  = ex_mem_read && ex_match;
    branch_hz = id_branch && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    hz_stall  = !md_stall && (load_use || branch_hz);
  end

  // mul/div holds ID/EX in place; a data hazard bubbles it instead
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    md_busy      = 1'b0;
    if (reset) begin
      stall_pc     = md_stall || hz_stall;
      stall_if_id  = md_stall || hz_stall;
      flush_if_id  = id_redirect && !(md_stall || hz_stall);
      stall_id_ex  = md_stall;
      flush_id_ex  = hz_stall;
      flush_ex_mem = md_stall;
      md_busy      = md_stall;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc)    perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush_if_id) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
